// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI slave transaction sequencer.
package spi_xfer_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  // Value of the R/W bit (LSB of the first byte) that selects a read.
  localparam logic RW_READ = 1'b1;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ADDR        = 4'd1,
    DECODE      = 4'd2,
    READ_FETCH  = 4'd3,
    READ_LOAD   = 4'd4,
    READ_SHIFT  = 4'd5,
    WRITE_SHIFT = 4'd6,
    WRITE_MEM   = 4'd7,
    DONE        = 4'd8
  } xferState_t;

endpackage

// File: rtl/spi_xfer_controller_bit_counter.sv
// SCLK edge counter for one SPI byte; clear has priority over increment.
module spi_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Count accepted edge pulses; the owner clears on every state change so it never wraps.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST) && inc;

endmodule

// File: rtl/spi_xfer_controller.sv
// Slave-side SPI transaction sequencer: counts SCLK edges, decodes the
// address/RW byte and sequences address latch, memory access and MISO drive.
module spi_xfer_controller
  import spi_xfer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic resetN,
  input  logic csN,
  input  logic sclkPosEdge,
  input  logic rwBit,
  output logic addrLatchEn,
  output logic srParallelLoad,
  output logic memWriteEn,
  output logic misoEnable,
  output logic busy,
  output logic overrun
);

  xferState_t       state;
  xferState_t       stateNext;
  logic [CNT_W-1:0] bitCount;
  logic             cntTerminal;
  logic             cntInc;
  logic             cntClr;
  logic             countingState;
  logic             singleCycleState;
  logic             overrunFlag;

  // A deasserted chip select wins over a coincident edge pulse.
  assign cntInc = countingState && sclkPosEdge && !csN;
  assign cntClr = !resetN || (stateNext != state);

  spi_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bitCounter (
    .clk      (clk),
    .clr      (cntClr),
    .inc      (cntInc),
    .count    (bitCount),
    .terminal (cntTerminal)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    stateNext        = state;
    countingState    = 1'b0;
    singleCycleState = 1'b0;
    addrLatchEn      = 1'b0;
    srParallelLoad   = 1'b0;
    memWriteEn       = 1'b0;
    misoEnable       = 1'b0;
    busy             = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (!csN) stateNext = ADDR;
      end
      ADDR: begin
        countingState = 1'b1;
        if (cntTerminal) stateNext = DECODE;
      end
      DECODE: begin
        singleCycleState = 1'b1;
        addrLatchEn      = 1'b1;
        stateNext        = (rwBit == RW_READ) ? READ_FETCH : WRITE_SHIFT;
      end
      READ_FETCH: begin
        singleCycleState = 1'b1;
        stateNext        = READ_LOAD;
      end
      READ_LOAD: begin
        singleCycleState = 1'b1;
        srParallelLoad   = 1'b1;
        stateNext        = READ_SHIFT;
      end
      READ_SHIFT: begin
        countingState = 1'b1;
        misoEnable    = 1'b1;
        if (cntTerminal) stateNext = DONE;
      end
      WRITE_SHIFT: begin
        countingState = 1'b1;
        if (cntTerminal) stateNext = WRITE_MEM;
      end
      WRITE_MEM: begin
        singleCycleState = 1'b1;
        memWriteEn       = 1'b1;
        stateNext        = DONE;
      end
      DONE: begin
        stateNext = DONE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Chip select released aborts any transaction in flight.
    if (state != IDLE && csN) stateNext = IDLE;
  end

  // Sticky overrun: edge pulse seen in a single-cycle state; cleared on a new transaction.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      overrunFlag <= 1'b0;
    end else if (state == IDLE && !csN) begin
      overrunFlag <= 1'b0;
    end else if (singleCycleState && sclkPosEdge && !csN) begin
      overrunFlag <= 1'b1;
    end
  end

  assign overrun = overrunFlag;

endmodule

// File: tb/tb_spi_xfer_controller.sv
// Scoreboard bench for spi_xfer_controller: stimulus pushes the expected
// output-vector changes with their cycle numbers; a negedge monitor pops and
// compares whenever the DUT output vector changes.
module tb_spi_xfer_controller;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic csN = 1'b1;
  logic sclkPosEdge = 1'b0;
  logic rwBit;
  logic mosi = 1'b0;
  logic addrLatchEn, srParallelLoad, memWriteEn, misoEnable, busy, overrun;

  localparam logic [5:0] BUSY = 6'b100000;
  localparam logic [5:0] ALE  = 6'b010000;
  localparam logic [5:0] LOAD = 6'b001000;
  localparam logic [5:0] MWE  = 6'b000100;
  localparam logic [5:0] MISO = 6'b000010;
  localparam logic [5:0] OVR  = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    string      name;
  } expEntry_t;

  expEntry_t  expQ[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       monOn = 1'b0;
  logic [5:0] prevVec = '0;
  logic [7:0] sr = '0;
  logic [5:0] outVec;

  assign outVec = {busy, addrLatchEn, srParallelLoad, memWriteEn, misoEnable, overrun};
  assign rwBit  = sr[0];

  spi_xfer_controller dut (
    .clk            (clk),
    .resetN         (resetN),
    .csN            (csN),
    .sclkPosEdge    (sclkPosEdge),
    .rwBit          (rwBit),
    .addrLatchEn    (addrLatchEn),
    .srParallelLoad (srParallelLoad),
    .memWriteEn     (memWriteEn),
    .misoEnable     (misoEnable),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the shift register feeding rwBit.
  always @(posedge clk) if (sclkPosEdge) sr <= {sr[6:0], mosi};

  always @(negedge clk) begin
    if (monOn && outVec !== prevVec) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, outVec, prevVec);
      end else begin
        expEntry_t e;
        e = expQ.pop_front();
        if (outVec !== e.vec || cyc != e.cyc) begin
          failures++;
          $display("FAIL %s got cyc=%0d vec=%b required cyc=%0d vec=%b",
                   e.name, cyc, outVec, e.cyc, e.vec);
        end
      end
      prevVec = outVec;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input int c, input logic [5:0] v, input string n);
    expEntry_t e;
    e.cyc  = c;
    e.vec  = v;
    e.name = n;
    expQ.push_back(e);
  endtask

  // One-clk edge pulse; returns the clock edge that samples it, no trailing gap.
  task automatic sendPulse(output int edgeNum);
    sclkPosEdge = 1'b1;
    edgeNum = cyc + 1;
    step(1);
    sclkPosEdge = 1'b0;
  endtask

  // Eight pulses MSB first, 4 clk apart; returns the edge of the last one.
  task automatic xferByte(input logic [7:0] b, output int lastEdge);
    int e;
    e = 0;
    for (int i = 0; i < 8; i++) begin
      mosi = b[7-i];
      sendPulse(e);
      if (i < 7) step(3);
    end
    lastEdge = e;
  endtask

  task automatic csLow(input string n);
    csN = 1'b0;
    pushExp(cyc + 1, BUSY, n);
    step(1);
  endtask

  task automatic csHigh(input logic [5:0] v, input string n);
    csN = 1'b1;
    pushExp(cyc + 1, v, n);
    step(1);
  endtask

  initial begin
    int k, k2;
    // Reset state
    resetN = 1'b0;
    csN = 1'b1;
    step(2);
    checks++;
    if (outVec !== 6'b0) begin
      failures++;
      $display("FAIL reset_state got=%b required=%b", outVec, 6'b0);
    end
    prevVec = 6'b0;
    monOn = 1'b1;
    resetN = 1'b1;
    step(2);

    // Write: address 0x2B, rw=0, data 0xA5
    csLow("wr_busy");
    xferByte(8'h56, k);
    pushExp(k, BUSY | ALE, "wr_ale");
    pushExp(k + 1, BUSY, "wr_shift");
    step(3);
    xferByte(8'hA5, k2);
    pushExp(k2, BUSY | MWE, "wr_mwe");
    pushExp(k2 + 1, BUSY, "wr_done");
    step(3);
    csHigh(6'b0, "wr_idle");
    step(3);

    // Read: address 0x2B, rw=1
    csLow("rd_busy");
    xferByte(8'h57, k);
    pushExp(k, BUSY | ALE, "rd_ale");
    pushExp(k + 1, BUSY, "rd_fetch");
    pushExp(k + 2, BUSY | LOAD, "rd_load");
    pushExp(k + 3, BUSY | MISO, "rd_miso_on");
    step(3);
    xferByte(8'hFF, k2);
    pushExp(k2, BUSY, "rd_miso_off");
    step(3);
    csHigh(6'b0, "rd_idle");
    step(3);

    // Abort after 5 pulses, then a fresh transaction must decode from bit 0
    csLow("ab_busy");
    for (int i = 0; i < 5; i++) begin
      sendPulse(k);
      step(3);
    end
    csHigh(6'b0, "ab_idle");
    step(3);
    csLow("ab2_busy");
    xferByte(8'h56, k);
    pushExp(k, BUSY | ALE, "ab2_ale");
    pushExp(k + 1, BUSY, "ab2_shift");
    step(3);
    csHigh(6'b0, "ab2_idle");
    step(3);

    // Collision: csN rises with the 8th address pulse
    csLow("col_busy");
    for (int i = 0; i < 7; i++) begin
      sendPulse(k);
      step(3);
    end
    sclkPosEdge = 1'b1;
    csN = 1'b1;
    pushExp(cyc + 1, 6'b0, "col_idle");
    step(1);
    sclkPosEdge = 1'b0;
    step(6);

    // Overrun: extra pulse while in DECODE
    csLow("ov_busy");
    xferByte(8'h56, k);
    pushExp(k, BUSY | ALE, "ov_ale");
    pushExp(k + 1, BUSY | OVR, "ov_set");
    sclkPosEdge = 1'b1;
    step(1);
    sclkPosEdge = 1'b0;
    step(3);
    xferByte(8'hA5, k2);
    pushExp(k2, BUSY | MWE | OVR, "ov_mwe");
    pushExp(k2 + 1, BUSY | OVR, "ov_done");
    step(3);
    csHigh(OVR, "ov_idle_sticky");
    step(2);
    csLow("ov_clear");
    step(1);
    csHigh(6'b0, "ov_idle2");
    step(3);

    // Reset in WRITE_SHIFT after 3 data bits
    csLow("rs_busy");
    xferByte(8'h56, k);
    pushExp(k, BUSY | ALE, "rs_ale");
    pushExp(k + 1, BUSY, "rs_shift");
    step(3);
    for (int i = 0; i < 3; i++) begin
      sendPulse(k);
      step(3);
    end
    resetN = 1'b0;
    pushExp(cyc + 1, 6'b0, "rs_reset");
    step(1);
    csN = 1'b1;
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sendPulse(k);
      step(3);
    end
    step(4);

    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got=%0d required=0 next=%s", expQ.size(), expQ[0].name);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/spi_xfer_controller.md
Name: spi_xfer_controller

Overview:
- Slave-side transaction sequencer for the SPI memory path.
- Counts conditioned SCLK edge pulses while chip select is low and decodes the address/RW byte.
- Drives the 8-bit shift register's parallelLoad, the address-latch enable, the data-memory write enable and the MISO tri-state enable.
- Sits between the input conditioners (synchronised csN, sclk edge pulses) and the shift register / address latch / data memory.

Parameters:
WIDTH, 8, bits per SPI byte; also the shift register width.
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock; every register updates on posedge clk.
resetN  in  1  synchronous, active-low reset.
csN  in  1  chip select, active low, already synchronised.
sclkPosEdge  in  1  one-clk pulse per SCLK rising edge; the same pulse drives the shift register's peripheralClkEdge.
rwBit  in  1  shift register parallelDataOut[0]; 1 = read, 0 = write.
addrLatchEn  out  1  one-clk pulse: latch parallelDataOut[WIDTH-1:1] as the address.
srParallelLoad  out  1  one-clk pulse to the shift register's parallelLoad (memory data to shift register).
memWriteEn  out  1  one-clk pulse: write parallelDataOut to memory at the latched address.
misoEnable  out  1  MISO driver enable; level signal.
busy  out  1  high in every state except IDLE.
overrun  out  1  sticky: an sclkPosEdge arrived in a single-cycle state.

Behaviour:
- Reset (resetN=0 at posedge clk):
  - state=IDLE, counter=0, overrun=0.
  - All outputs 0 from the next cycle; reset wins over every other input.
- Outputs are Moore-decoded from the registered state; counter is CNT_W bits, unsigned.
- States and transitions:
  - IDLE: csN=0 → ADDR, counter=0, overrun cleared.
  - ADDR: each sclkPosEdge increments counter. The pulse arriving with counter==WIDTH-1 → DECODE, counter=0.
  - DECODE (1 clk): addrLatchEn=1. rwBit=1 → READ_FETCH; rwBit=0 → WRITE_SHIFT.
  - READ_FETCH (1 clk): memory read access cycle, no outputs.
  - READ_LOAD (1 clk): srParallelLoad=1 → READ_SHIFT.
  - READ_SHIFT: misoEnable=1; counts WIDTH sclkPosEdge pulses, then → DONE.
  - WRITE_SHIFT: counts WIDTH sclkPosEdge pulses, then → WRITE_MEM.
  - WRITE_MEM (1 clk): memWriteEn=1 → DONE.
  - DONE: ignores edges; csN=1 → IDLE.
- Latency: if the final counted pulse is sampled at edge k, the next state is entered at k+1.
  - addrLatchEn is high in cycle k+1.
  - On a read, srParallelLoad is high in cycle k+3.
  - On a write, memWriteEn is high in cycle k+1 after the WIDTH-th data pulse.
- csN=1 in any non-IDLE state:
  - Abort: → IDLE next clk, counter=0.
  - No pending addrLatchEn, srParallelLoad or memWriteEn issues.
- csN=1 coinciding with an sclkPosEdge: csN wins; the pulse is neither counted nor acted on.
- sclkPosEdge while in DECODE, READ_FETCH, READ_LOAD or WRITE_MEM:
  - Pulse is ignored; overrun set to 1.
  - overrun holds until the next IDLE→ADDR transition or reset.
  - System requirement: SCLK pulses are spaced at least 4 clk apart.
- Counter never wraps; it is cleared on every state change.
- csN held low after DONE: no further transaction until csN has returned high.

Decomposition:
- Package spi_xfer_pkg holds:
  - state encoding constants: IDLE, ADDR, DECODE, READ_FETCH, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE (4-bit);
  - RW_READ=1;
  - default WIDTH.
- One sub-module, spi_bit_counter:
  - ports: clr, inc, count, terminal;
  - terminal = (count==WIDTH-1) && inc.
- FSM, output decode and overrun flag stay in spi_xfer_controller.

Test Plan:
- Write: reset, csN=0, 8 pulses shifting 0x56 (addr 0x2B, rw=0), then 8 pulses of 0xA5 → addrLatchEn 1 clk after the 8th addr pulse; memWriteEn 1 clk after the 16th pulse; misoEnable stays 0; then DONE; csN=1 → IDLE, busy=0.
- Read: 8 pulses shifting 0x57 (addr 0x2B, rw=1) → addrLatchEn at k+1, srParallelLoad at k+3; misoEnable rises at k+4 and falls 1 clk after the 8th read pulse; memWriteEn stays 0.
- Abort: csN=0, 5 pulses, csN=1 → IDLE next clk, counter=0, no enable pulses. Next transaction decodes correctly from bit 0.
- Collision: csN rises in the same clk as the 8th address pulse → no addrLatchEn; state IDLE.
- Overrun: pulse injected 1 clk after the 8th address pulse (in DECODE) → overrun=1, pulse not counted; overrun stays 1 through DONE and clears on the next csN fall.
- Reset mid-op: resetN=0 during WRITE_SHIFT at bit 3 → all outputs 0 next clk, state IDLE; memWriteEn never pulses.
